// File: rtl/mplc_port_pkg.sv
// Shared definitions for the memory port master: FSM state encoding,
// address-region helpers, semaphore bank offsets and the release bit.
// No ports; imported by the port master and its wait timer.
package mplc_port_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ACCESS  = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;

    // Address bit that turns a read into a read-and-release.
    localparam int REL_BIT = 7;

    // Offsets of the three semaphore banks (one per CPU) inside semaphore space.
    localparam logic [4:0] SEM_BANK_0 = 5'h00;
    localparam logic [4:0] SEM_BANK_1 = 5'h08;
    localparam logic [4:0] SEM_BANK_2 = 5'h10;

    // A[11:10]==00 selects the plain bit memory.
    function automatic logic region_mem(input logic [11:0] adr);
        return (adr[11:10] == 2'b00);
    endfunction

    // A[11]==1 selects the semaphore space.
    function automatic logic region_sem(input logic [11:0] adr);
        return adr[11];
    endfunction

endpackage

// File: rtl/mplc_wait_timer.sv
// Stall timer for the memory port master.
// Saturating up-counter of stalled cycles; expired is high while the count
// sits at TMO_MAX-1, i.e. the next stalled edge is the TMO_MAX-th one.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count one stalled cycle
//   expired    : timeout reached (never asserted when TMO_MAX==0)
module mplc_wait_timer #(
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_MAX - 1);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {TMO_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TMO_MAX != 0) && (count_q == LAST);

endmodule

// File: rtl/mplc_mem_port_master.sv
// CPU-side initiator for one port of the 3-CPU shared bit memory.
// Takes single-bit read/write requests from a logic core, drives the
// memory port, holds the access while WT is low and aborts after TMO_MAX
// stalled cycles.
// Ports:
//   CLK, CLR          : clock, asynchronous active-low reset
//   REQ, REQ_WE, REQ_REL, REQ_ADR, REQ_DI : request from the core (sampled when idle)
//   BUSY, ACK, ERR, RDATA : status/result to the core (all registered)
//   A, DI, WE, OE     : memory port drive (all registered)
//   WT, DQ            : memory ready and read data
//
// state    | meaning
// IDLE     | no access; accepts REQ
// ACCESS   | WE or OE asserted, waiting for WT=1 (timer running while WT=0)
// CAPTURE  | memory registered the read address; DQ sampled on the next edge
module mplc_mem_port_master #(
    parameter int AW      = 12,
    parameter int TMO_W   = 8,
    parameter int TMO_MAX = 200,
    parameter int REL_BIT = mplc_port_pkg::REL_BIT
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          REQ,
    input  logic          REQ_WE,
    input  logic          REQ_REL,
    input  logic [AW-1:0] REQ_ADR,
    input  logic          REQ_DI,
    output logic          BUSY,
    output logic          ACK,
    output logic          ERR,
    output logic          RDATA,
    output logic [AW-1:0] A,
    output logic          DI,
    output logic          WE,
    output logic          OE,
    input  logic          WT,
    input  logic          DQ
);

    import mplc_port_pkg::*;

    state_t        state_q, state_d;
    logic [AW-1:0] a_q, a_d;
    logic          di_q, di_d;
    logic          we_q, we_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;
    logic          rdata_q, rdata_d;

    logic          tmr_clr;
    logic          tmr_en;
    logic          tmr_expired;

    mplc_wait_timer #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_wait_timer (
        .clk     (CLK),
        .rst_n   (CLR),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        di_d    = di_q;
        we_d    = we_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    a_d = REQ_ADR;
                    // Release is a read-only modifier; writes keep the address as given.
                    if (!REQ_WE) begin
                        a_d[REL_BIT] = REQ_ADR[REL_BIT] | REQ_REL;
                    end
                    di_d    = REQ_DI;
                    we_d    = REQ_WE;
                    oe_d    = ~REQ_WE;
                    busy_d  = 1'b1;
                    tmr_clr = 1'b1;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (WT) begin
                    if (we_q) begin
                        // Memory commits the write on this edge.
                        we_d    = 1'b0;
                        a_d     = '0;
                        di_d    = 1'b0;
                        ack_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        // Memory registers the read address on this edge; keep A/OE.
                        state_d = ST_CAPTURE;
                    end
                end else if (tmr_expired) begin
                    we_d    = 1'b0;
                    oe_d    = 1'b0;
                    a_d     = '0;
                    di_d    = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            ST_CAPTURE: begin
                rdata_d = DQ;
                oe_d    = 1'b0;
                a_d     = '0;
                di_d    = 1'b0;
                ack_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                we_d    = 1'b0;
                oe_d    = 1'b0;
                a_d     = '0;
                di_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            di_q    <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            di_q    <= di_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign A     = a_q;
    assign DI    = di_q;
    assign WE    = we_q;
    assign OE    = oe_q;
    assign BUSY  = busy_q;
    assign ACK   = ack_q;
    assign ERR   = err_q;
    assign RDATA = rdata_q;

endmodule

// File: tb/tb_mplc_mem_port_master.sv
// Self-checking bench for mplc_mem_port_master: a directed vector table,
// hand-written timeout / reset sequences and randomized transactions scored
// against a transaction-level reference memory.
module tb_mplc_mem_port_master;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    always #5 CLK = ~CLK;

    logic        req, req4, req_we, req_rel, req_di, wt;
    logic [11:0] req_adr;

    logic        busy, ack, err, rdata, di, we, oe, dq;
    logic [11:0] a;
    logic        busy4, ack4, err4, rdata4, di4, we4, oe4;
    logic [11:0] a4;

    mplc_mem_port_master #(.AW(12), .TMO_W(8), .TMO_MAX(200), .REL_BIT(7)) dut (
        .CLK(CLK), .CLR(CLR), .REQ(req), .REQ_WE(req_we), .REQ_REL(req_rel),
        .REQ_ADR(req_adr), .REQ_DI(req_di), .BUSY(busy), .ACK(ack), .ERR(err),
        .RDATA(rdata), .A(a), .DI(di), .WE(we), .OE(oe), .WT(wt), .DQ(dq)
    );

    mplc_mem_port_master #(.AW(12), .TMO_W(8), .TMO_MAX(4), .REL_BIT(7)) dut4 (
        .CLK(CLK), .CLR(CLR), .REQ(req4), .REQ_WE(req_we), .REQ_REL(req_rel),
        .REQ_ADR(req_adr), .REQ_DI(req_di), .BUSY(busy4), .ACK(ack4), .ERR(err4),
        .RDATA(rdata4), .A(a4), .DI(di4), .WE(we4), .OE(oe4), .WT(wt), .DQ(dq)
    );

    // Memory device model: registered address, combinational read data.
    logic        mem [0:4095];
    logic [11:0] mem_addr_q;
    logic        load_en;
    logic [11:0] load_adr;
    logic        load_val;

    always @(posedge CLK) begin
        mem_addr_q <= a;
        if (load_en) mem[load_adr] <= load_val;
        else if (we && wt) mem[a] <= di;
    end
    assign dq = mem[mem_addr_q];

    // Reference model state.
    bit   ref_mem [0:4095];
    logic cur_rdata;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        bit          we;
        bit          rel;
        logic [11:0] adr;
        bit          di;
        int          stalls;
        logic [11:0] exp_a;
        int          exp_lat;
        bit          exp_rd;
        int          gap;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req = 1'b0;
            @(posedge CLK); @(negedge CLK);
            chk("idle_ack_busy", {30'd0, ack, busy}, 32'd0);
        end
    endtask

    // Starts at a negedge with the main DUT idle; ends at the negedge of the ACK cycle.
    task automatic do_txn(input bit we_i, input bit rel_i, input logic [11:0] adr_i,
                          input bit di_i, input int stalls, input logic [11:0] exp_a,
                          input int exp_lat, input bit exp_rd, input string tag);
        int  got;
        int  st_cnt;
        bit  a_ok;
        req = 1'b1; req_we = we_i; req_rel = rel_i; req_adr = adr_i; req_di = di_i;
        wt = 1'($urandom_range(0, 1));
        @(posedge CLK); @(negedge CLK);
        req = 1'($urandom_range(0, 1));
        req_we = 1'($urandom_range(0, 1)); req_rel = 1'($urandom_range(0, 1));
        req_adr = 12'($urandom_range(0, 4095)); req_di = 1'($urandom_range(0, 1));
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_addr"}, 32'(a), 32'(exp_a));
        chk({tag, "_strobes"}, {30'd0, we, oe}, {30'd0, we_i, ~we_i});
        if (we_i) chk({tag, "_wdata"}, 32'(di), 32'(di_i));
        st_cnt = we_i ? int'(we) : int'(oe);
        a_ok = 1'b1;
        got = 0;
        for (int k = 1; k <= 60; k++) begin
            wt = (k > stalls);
            @(posedge CLK); @(negedge CLK);
            if (ack) begin
                got = k + 1;
                break;
            end
            st_cnt += we_i ? int'(we) : int'(oe);
            if (a !== exp_a) a_ok = 1'b0;
            req = 1'($urandom_range(0, 1));
            req_adr = 12'($urandom_range(0, 4095));
        end
        req = 1'b0;
        if (got == 0) begin
            chk({tag, "_ack_seen"}, 32'd0, 32'd1);
            return;
        end
        chk({tag, "_latency"}, 32'(got), 32'(exp_lat));
        chk({tag, "_strobe_cycles"}, 32'(st_cnt), 32'(we_i ? stalls + 1 : stalls + 2));
        chk({tag, "_addr_stable"}, 32'(a_ok), 32'd1);
        chk({tag, "_ack_state"}, {27'd0, err, we, oe, busy, di}, 32'd0);
        chk({tag, "_ack_addr"}, 32'(a), 32'd0);
        chk({tag, "_rdata"}, 32'(rdata), 32'(exp_rd));
        if (we_i) ref_mem[exp_a] = di_i;
        cur_rdata = exp_rd;
    endtask

    task automatic wait_ack4(output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge CLK); @(negedge CLK);
            if (ack4) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        bit          b;
        bit          r_we, r_rel, r_di;
        logic [11:0] r_adr, eff;
        int          r_st;

        req = 0; req4 = 0; req_we = 0; req_rel = 0; req_di = 0; req_adr = '0; wt = 1;
        load_en = 0; load_adr = '0; load_val = 0;

        // Reset state.
        @(negedge CLK);
        chk("reset_main", {13'd0, busy, ack, err, rdata, di, we, oe, a}, 32'd0);
        chk("reset_t4", {13'd0, busy4, ack4, err4, rdata4, di4, we4, oe4, a4}, 32'd0);

        // Preload device memory and the reference copy while in reset.
        load_en = 1'b1;
        for (int i = 0; i < 4096; i++) begin
            b = 1'($urandom_range(0, 1));
            if (i == 0 || i == 12'h808) b = 1'b1;
            if (i == 5 || i == 12'h800 || i == 12'h880 || i == 12'h333) b = 1'b0;
            load_adr = 12'(i); load_val = b; ref_mem[i] = b;
            @(negedge CLK);
        end
        load_en = 1'b0;
        chk("reset_held_main", {13'd0, busy, ack, err, rdata, di, we, oe, a}, 32'd0);
        CLR = 1'b1;
        cur_rdata = 1'b0;
        idle(2);

        // Directed vector table.
        vecs[0] = '{we:1, rel:0, adr:12'h005, di:1, stalls:0, exp_a:12'h005, exp_lat:2, exp_rd:0, gap:0};
        vecs[1] = '{we:0, rel:0, adr:12'h005, di:0, stalls:0, exp_a:12'h005, exp_lat:3, exp_rd:1, gap:1};
        vecs[2] = '{we:0, rel:0, adr:12'h808, di:0, stalls:5, exp_a:12'h808, exp_lat:8, exp_rd:1, gap:1};
        vecs[3] = '{we:0, rel:1, adr:12'h800, di:0, stalls:0, exp_a:12'h880, exp_lat:3, exp_rd:0, gap:0};
        vecs[4] = '{we:1, rel:1, adr:12'h800, di:1, stalls:2, exp_a:12'h800, exp_lat:4, exp_rd:0, gap:2};
        vecs[5] = '{we:0, rel:0, adr:12'h800, di:0, stalls:1, exp_a:12'h800, exp_lat:4, exp_rd:1, gap:1};
        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].we, vecs[i].rel, vecs[i].adr, vecs[i].di, vecs[i].stalls,
                   vecs[i].exp_a, vecs[i].exp_lat, vecs[i].exp_rd, $sformatf("vec%0d", i));
            idle(vecs[i].gap);
        end

        // Timeout instance: first a good read (returns mem[0] since main port is idle).
        req4 = 1; req_we = 0; req_rel = 0; req_adr = 12'h123; wt = 1;
        @(posedge CLK); @(negedge CLK);
        req4 = 0;
        wait_ack4(n);
        chk("t4_read_lat", 32'(n), 32'd2);
        chk("t4_read_data", 32'(rdata4), 32'd1);
        chk("t4_read_err", 32'(err4), 32'd0);
        @(negedge CLK);

        // Read with WT stuck low: abort after exactly 4 stalled edges.
        req4 = 1; req_we = 0; req_adr = 12'h808; wt = 0;
        @(posedge CLK); @(negedge CLK);
        req4 = 0;
        chk("t4_stall_oe", {30'd0, busy4, oe4}, 32'd3);
        wait_ack4(n);
        chk("t4_timeout_edges", 32'(n), 32'd4);
        chk("t4_timeout_err", 32'(err4), 32'd1);
        chk("t4_timeout_drop", {29'd0, we4, oe4, busy4}, 32'd0);
        chk("t4_timeout_addr", 32'(a4), 32'd0);
        chk("t4_timeout_rdata", 32'(rdata4), 32'd1);
        // New request accepted in the ACK cycle.
        req4 = 1; req_we = 1; req_adr = 12'h00A; req_di = 1;
        @(posedge CLK); @(negedge CLK);
        req4 = 0;
        chk("t4_b2b_accept", {28'd0, busy4, we4, oe4, di4}, 32'b1101);
        chk("t4_b2b_addr", 32'(a4), 32'h00A);
        wait_ack4(n);
        chk("t4_wr_timeout_edges", 32'(n), 32'd4);
        chk("t4_wr_timeout_flags", {29'd0, err4, we4, busy4}, 32'b100);
        @(negedge CLK);
        chk("t4_pulse_once", {30'd0, ack4, err4}, 32'd0);
        wt = 1;
        idle(1);

        // Reset in the middle of a stalled write.
        req = 1; req_we = 1; req_rel = 0; req_adr = 12'h333; req_di = 1; wt = 0;
        @(posedge CLK); @(negedge CLK);
        req = 0;
        chk("rst_mid_we_before", 32'(we), 32'd1);
        #2 CLR = 1'b0;
        #1 chk("rst_mid_drop", {16'd0, we, oe, busy, ack, a}, 32'd0);
        @(negedge CLK);
        chk("rst_mid_no_ack", {30'd0, ack, ack4}, 32'd0);
        @(negedge CLK);
        CLR = 1'b1;
        cur_rdata = 1'b0;
        wt = 1;
        idle(1);
        // Write never committed; then a normal write/read pair.
        do_txn(0, 0, 12'h333, 0, 0, 12'h333, 3, ref_mem[12'h333], "rst_readback");
        do_txn(1, 0, 12'h333, 1, 1, 12'h333, 3, cur_rdata, "rst_write");
        do_txn(0, 0, 12'h333, 0, 0, 12'h333, 3, 1'b1, "rst_read");
        idle(1);

        // Randomized transactions against the reference memory.
        for (int t = 0; t < 60; t++) begin
            r_we  = 1'($urandom_range(0, 1));
            r_rel = 1'($urandom_range(0, 1));
            r_di  = 1'($urandom_range(0, 1));
            r_adr = 12'($urandom_range(0, 4095));
            r_st  = int'($urandom_range(0, 6));
            eff   = (!r_we && r_rel) ? (r_adr | 12'h080) : r_adr;
            do_txn(r_we, r_rel, r_adr, r_di, r_st, eff, (r_we ? 2 : 3) + r_st,
                   r_we ? cur_rdata : ref_mem[eff], $sformatf("rnd%0d", t));
            idle(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mplc_mem_port_master.md
Name: mplc_mem_port_master

Overview:
- CPU-side initiator for one port (A_n/DI_n/DQ_n/WE_n/OE_n/WT_n) of the 3-CPU shared bit memory with semaphores.
- Accepts single-bit read/write requests from a logic core and drives the memory port. Holds the access while WT is low, so a semaphore access stalls until the partner core's semaphore is ready.
- Captures read data one cycle after the memory registers the address.
- A timeout aborts an access after a bounded stall; one instance sits beside each core.

Parameters:
- AW, 12, address width; must match the memory port address width.
- TMO_W, 8, timeout counter width.
- TMO_MAX, 200, maximum stall cycles while WT=0 before abort; 0 disables the timeout.
- REL_BIT, 7, address bit that signals semaphore release on a read.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  asynchronous, active-low reset.
- REQ  in  1  request strobe; sampled only when BUSY=0.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_REL  in  1  read-and-release; forces A[REL_BIT]=1 during the read.
- REQ_ADR  in  AW  target address (A[11:10]=00 bit memory, A[11]=1 semaphore space).
- REQ_DI  in  1  write data.
- BUSY  out  1  access in progress.
- ACK  out  1  one-cycle completion pulse.
- ERR  out  1  one-cycle timeout pulse, coincident with ACK.
- RDATA  out  1  read result; valid from the ACK cycle until the next read ACK.
- A  out  AW  memory port address.
- DI  out  1  memory port write data.
- WE  out  1  memory port write enable.
- OE  out  1  memory port output enable.
- WT  in  1  memory ready; 1 = access may complete this edge.
- DQ  in  1  memory read data; combinational from the memory's registered address.

Behaviour:
- Reset (CLR=0, asynchronous): state IDLE, timer=0. A, DI, WE, OE, BUSY, ACK, ERR and RDATA are all 0.
- All outputs are registered. Every state change happens on the rising edge of CLK.
- States: IDLE, ACCESS, CAPTURE.
- IDLE:
  - BUSY=0.
  - On REQ=1, load A=REQ_ADR, with A[REL_BIT] OR'd with REQ_REL when REQ_WE=0.
  - Load DI=REQ_DI.
  - Set WE=REQ_WE and OE=~REQ_WE. Set BUSY=1 and clear the timer. Go to ACCESS.
- ACCESS (WE or OE held, A and DI stable):
  - WT=1 and write: clear WE, A and DI; pulse ACK next cycle; go to IDLE. The memory has committed the write on this edge.
  - WT=1 and read: keep A and OE; go to CAPTURE. The memory registers the address on this edge.
  - WT=0: increment the timer. When timer==TMO_MAX-1 and TMO_MAX!=0, clear WE/OE/A; pulse ACK and ERR; go to IDLE. RDATA is unchanged on abort.
- CAPTURE:
  - RDATA<=DQ; clear OE and A; pulse ACK; go to IDLE.
- Latency from the REQ edge to the ACK cycle, with no stall: write = 2 cycles, read = 3 cycles. Each stall cycle adds 1.
- ACK is visible in the cycle in which the state has already returned to IDLE. A REQ in that same cycle is accepted, giving back-to-back operation.
- REQ while BUSY=1 is ignored; no queueing.
- REQ_* inputs are sampled only at acceptance. Later changes to them have no effect on the access in progress.
- WT is ignored in IDLE and CAPTURE.
- Timeout fires at exactly TMO_MAX stalled cycles. The timer saturates and never wraps.
- Reset mid-access drops WE/OE immediately, asynchronously. The interrupted access is not acknowledged.

Decomposition:
- Shared package mplc_port_pkg holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, CAPTURE=2'd2);
  - the region constants REGION_MEM = A[11:10]==2'b00 and REGION_SEM = A[11]==1;
  - the semaphore bank offsets 5'h00, 5'h08 and 5'h10;
  - REL_BIT.
- Sub-module mplc_wait_timer: a TMO_W-bit saturating counter with clear, enable and an expiry output.

Test Plan:
- Write with WT tied 1: REQ, REQ_WE=1, ADR=12'h005, DI=1 → WE=1 and A=12'h005 for exactly 1 cycle; ACK pulse on the 2nd cycle after REQ; ERR=0.
- Read with WT=1 and a memory model returning 1 at addr 5: REQ, REQ_WE=0, ADR=12'h005 → OE high for 2 cycles; ACK on the 3rd cycle; RDATA=1.
- Semaphore read stall: ADR=12'h808 with WT held 0 for 5 cycles, then 1, with DQ=1 → ACK 5 cycles later than the read in scenario 2; RDATA=1; A[7]=0.
- Read-and-release: REQ_REL=1, ADR=12'h800 → A=12'h880 while OE=1; REQ_REL ignored on a write (A=12'h800).
- Timeout with TMO_MAX=4: WT stuck 0 → ACK=ERR=1 in the cycle after 4 stalled edges; WE/OE=0; RDATA unchanged; a new REQ is accepted in that cycle.
- Reset mid-ACCESS: CLR low between clock edges → WE/OE/BUSY drop at once with no ACK; after release, a REQ completes normally.
